onehot_rr_scanner: RTL and testbench
====================================

# onehot_rr_scanner

Sticky 32-line request collector and round-robin serializer. It sits directly upstream of the 32-to-5 one-hot encoder stage. It captures single-cycle request pulses into a pending register and offers them one at a time as a clean one-hot word under a valid/ready handshake, so the encoder never sees multi-hot or zero input while valid is high.

## Interface
- WIDTH, 32: number of request lines; one-hot output width.
- IDX_W, 5: log2(WIDTH); width of the pointer and index.
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  WIDTH  request pulses; any high bit sets the matching pending bit.
- en  input  1  scan enable; new offers start only while en=1.
- out_ready  input  1  downstream accepts the current offer.
- out_valid  output  1  offer present.
- out_onehot  output  WIDTH  exactly one bit set when out_valid=1; all zero otherwise.
- pending  output  WIDTH  current sticky pending vector, registered.
- drop_cnt  output  8  saturating count of requests merged into an already-pending bit.

## Operation
- FSM has two states.
  - IDLE: out_valid=0, out_onehot=0.
  - OFFER: out_valid=1, out_onehot holds the selected bit.
- Pending update each edge: pending_next = (pending & ~granted) | req.
  - granted = out_onehot when out_valid & out_ready, else 0.
  - req on a bit granted in the same cycle leaves that bit set; it is a new event, not a drop.
- drop_cnt increments by 1 per cycle in which (req & pending & ~granted) != 0. It counts at most 1 per cycle and saturates at 255.
- Selection is round-robin over the search vector S = (pending & ~granted) | req.
  - Search starts at index ptr and scans upward, wrapping from WIDTH-1 to 0.
  - The first set bit wins.
- ptr update: on handshake, ptr <= granted index + 1, mod WIDTH. Otherwise ptr is unchanged.
- IDLE -> OFFER when en=1 and S != 0. Register the selected one-hot.
- OFFER with no handshake: hold out_onehot stable. Ignore en and req for the offered value.
- OFFER with handshake:
  - If en=1 and S != 0, stay in OFFER with the new selection (back-to-back, 1 grant/cycle).
  - Otherwise go to IDLE.
- en=0 never retracts an offer already made. It only blocks starting the next one.
- Reset values: state=IDLE, out_valid=0, out_onehot=0, pending=0, ptr=0, drop_cnt=0.

## Timing
- Latency: a req pulse at edge k sets pending at k. out_valid rises at edge k at the earliest, since the selection uses req directly. It is visible in the cycle after edge k.
- Throughput: one grant per cycle while out_ready=1 and requests remain.
- out_valid and out_onehot are registered; there is no combinational path from the inputs to the outputs.
- rst_n low mid-offer clears every output immediately (asynchronously). There is no partial grant.
- WIDTH=32 wrap: after granting bit 31, ptr=0.

## Structure
- Shared package holds:
  - WIDTH and IDX_W constants.
  - The state enum {IDLE, OFFER}.
  - The DROP_W=8 constant.
- One sub-module, rr_pick. It is purely combinational.
  - Inputs: S[WIDTH-1:0] and ptr[IDX_W-1:0].
  - Outputs: onehot[WIDTH-1:0], idx[IDX_W-1:0], any.
  - Implementation uses the double-width rotate-and-lowest-set-bit method.
- The top level holds the FSM, the pending, ptr and drop_cnt registers, and the handshake logic.

## Test plan
- Reset and single request:
  - Hold rst_n=0 and check all outputs are 0.
  - Release, set en=1, pulse req=32'h0000_0010 with out_ready=1.
  - Required: out_valid for 1 cycle with out_onehot=32'h10, then pending=0 and ptr=5.
- Round-robin wrap:
  - With ptr=5, pulse req=32'h8000_0001 and hold out_ready=1.
  - Required: grants 32'h8000_0000, then 32'h0000_0001. ptr ends at 1.
- Backpressure:
  - Pulse req=32'h0000_0006 with out_ready=0 for 4 cycles.
  - Required: out_onehot holds the same bit (32'h2 from ptr=0) for all 4 cycles.
  - Then raise out_ready. Required: 32'h4 follows the next cycle.
- Drop and merge:
  - With bit 3 pending and not granted, pulse req bit 3 three times.
  - Required: drop_cnt=3 and only one grant of bit 3.
  - Also drive 300 such merges. Required: drop_cnt=255.
- Simultaneous grant and re-request:
  - Handshake on bit 7 in the same cycle as a req bit 7 pulse.
  - Required: pending[7] remains 1 and a second grant of bit 7 occurs. drop_cnt is unchanged.
- en and reset mid-operation:
  - Drop en during an offer. Required: the offer completes on ready and no new offer follows.
  - Assert rst_n=0 mid-offer. Required: out_valid=0 and pending=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/onehot_rr_scanner_pkg.sv
// Shared constants and types for the round-robin request scanner.
// Imported by the picker and the top-level FSM.
package onehot_rr_scanner_pkg;

    localparam int WIDTH  = 32;
    localparam int IDX_W  = 5;
    localparam int DROP_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

endpackage

// File: rtl/onehot_rr_scanner_rr_pick.sv
// Combinational round-robin picker: first set bit of s at or above ptr,
// wrapping, via a double-width rotate and lowest-set-bit isolate.
module rr_pick
    import onehot_rr_scanner_pkg::*;
(
    input  logic [WIDTH-1:0] s,
    input  logic [IDX_W-1:0] ptr,
    output logic [WIDTH-1:0] onehot,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [2*WIDTH-1:0] dbl;
    logic [2*WIDTH-1:0] back;
    logic [WIDTH-1:0]   rot;
    logic [WIDTH-1:0]   low;

    // Rotate right so that bit ptr lands at position 0.
    assign dbl  = {s, s} >> ptr;
    assign rot  = dbl[WIDTH-1:0];
    assign low  = rot & (~rot + WIDTH'(1));
    assign back = {low, low} << ptr;

    assign onehot = back[2*WIDTH-1:WIDTH];
    assign any    = |s;

    always_comb begin
        idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (onehot[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/onehot_rr_scanner.sv
// Sticky request collector that serializes pending lines as a clean
// one-hot word under a valid/ready handshake, round-robin order.
module onehot_rr_scanner
    import onehot_rr_scanner_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  req,
    input  logic              en,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [WIDTH-1:0]  out_onehot,
    output logic [WIDTH-1:0]  pending,
    output logic [DROP_W-1:0] drop_cnt
);

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] off_idx;

    logic             hs;
    logic [WIDTH-1:0] granted;
    logic [WIDTH-1:0] search;
    logic             dropped;
    logic [WIDTH-1:0] pick_oh;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;
    logic             start;

    assign hs      = out_valid & out_ready;
    assign granted = hs ? out_onehot : '0;
    assign search  = (pending & ~granted) | req;
    assign dropped = |(req & pending & ~granted);
    assign start   = en & pick_any;

    rr_pick u_pick (
        .s      (search),
        .ptr    (ptr),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            out_valid  <= 1'b0;
            out_onehot <= '0;
            off_idx    <= '0;
            pending    <= '0;
            ptr        <= '0;
            drop_cnt   <= '0;
        end else begin
            pending <= search;

            if (dropped && drop_cnt != '1) begin
                drop_cnt <= drop_cnt + DROP_W'(1);
            end

            if (hs) begin
                ptr <= off_idx + IDX_W'(1);
            end

            // An offer is only replaced once it has been accepted.
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= OFFER;
                        out_valid  <= 1'b1;
                        out_onehot <= pick_oh;
                        off_idx    <= pick_idx;
                    end
                end
                OFFER: begin
                    if (hs) begin
                        if (start) begin
                            out_onehot <= pick_oh;
                            off_idx    <= pick_idx;
                        end else begin
                            state      <= IDLE;
                            out_valid  <= 1'b0;
                            out_onehot <= '0;
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    out_valid  <= 1'b0;
                    out_onehot <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_onehot_rr_scanner.sv
// Bench for onehot_rr_scanner: directed scenarios then random traffic,
// compared each cycle against an index-level reference model.
module tb_onehot_rr_scanner;

    import onehot_rr_scanner_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [WIDTH-1:0]  req = '0;
    logic              en = 1'b0;
    logic              out_ready = 1'b0;
    logic              out_valid;
    logic [WIDTH-1:0]  out_onehot;
    logic [WIDTH-1:0]  pending;
    logic [DROP_W-1:0] drop_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    bit m_pend [WIDTH];
    bit m_valid;
    int m_idx;
    int m_ptr;
    int m_drop;

    onehot_rr_scanner u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .en         (en),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_onehot (out_onehot),
        .pending    (pending),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < WIDTH; i++) m_pend[i] = 1'b0;
        m_valid = 1'b0;
        m_idx   = 0;
        m_ptr   = 0;
        m_drop  = 0;
    endfunction

    function automatic void model_step(input logic [WIDTH-1:0] r,
                                       input bit e, input bit rdy);
        int g;
        bit s [WIDTH];
        bit drop;
        int pick;
        g    = (m_valid && rdy) ? m_idx : -1;
        drop = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            s[i] = (m_pend[i] && i != g) || r[i];
            if (r[i] && m_pend[i] && i != g) drop = 1'b1;
        end
        if (drop && m_drop < 255) m_drop++;
        pick = -1;
        for (int k = 0; k < WIDTH; k++) begin
            if (pick < 0 && s[(m_ptr + k) % WIDTH]) pick = (m_ptr + k) % WIDTH;
        end
        if (g >= 0) m_ptr = (g + 1) % WIDTH;
        if (!m_valid || g >= 0) begin
            if (e && pick >= 0) begin
                m_valid = 1'b1;
                m_idx   = pick;
            end else begin
                m_valid = 1'b0;
            end
        end
        for (int i = 0; i < WIDTH; i++) m_pend[i] = s[i];
    endfunction

    function automatic logic [WIDTH-1:0] exp_onehot();
        return m_valid ? (WIDTH'(1) << m_idx) : '0;
    endfunction

    function automatic logic [WIDTH-1:0] exp_pending();
        logic [WIDTH-1:0] v;
        for (int i = 0; i < WIDTH; i++) v[i] = m_pend[i];
        return v;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".valid"},   32'(out_valid), 32'(m_valid));
        chk({tag, ".onehot"},  out_onehot, exp_onehot());
        chk({tag, ".pending"}, pending, exp_pending());
        chk({tag, ".drop"},    32'(drop_cnt), 32'(m_drop));
        chk({tag, ".ptr"},     32'(u_dut.ptr), 32'(m_ptr));
    endtask

    task automatic step(input logic [WIDTH-1:0] r, input bit e,
                        input bit rdy, input string tag);
        @(negedge clk);
        req       = r;
        en        = e;
        out_ready = rdy;
        @(posedge clk);
        model_step(r, e, rdy);
        #1;
        check_all(tag);
    endtask

    task automatic async_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk({tag, ".rst_valid"},   32'(out_valid), 32'd0);
        chk({tag, ".rst_onehot"},  out_onehot, 32'd0);
        chk({tag, ".rst_pending"}, pending, 32'd0);
        @(negedge clk);
        req       = '0;
        en        = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b1;
    endtask

    initial begin
        logic [WIDTH-1:0] r;
        model_reset();
        #12;
        check_all("reset");
        chk("reset.drop0", 32'(drop_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        step(32'h0000_0010, 1, 1, "single.offer");
        chk("single.oh", out_onehot, 32'h10);
        step(32'h0, 1, 1, "single.grant");
        chk("single.ptr5", 32'(u_dut.ptr), 32'd5);
        chk("single.pend0", pending, 32'h0);

        step(32'h8000_0001, 1, 1, "wrap.a");
        chk("wrap.oh31", out_onehot, 32'h8000_0000);
        step(32'h0, 1, 1, "wrap.b");
        chk("wrap.oh0", out_onehot, 32'h1);
        chk("wrap.ptr0", 32'(u_dut.ptr), 32'd0);
        step(32'h0, 1, 1, "wrap.c");
        chk("wrap.ptr1", 32'(u_dut.ptr), 32'd1);

        step(32'h6, 1, 0, "bp.0");
        for (int i = 0; i < 3; i++) begin
            step(32'h0, 1, 0, "bp.hold");
            chk("bp.oh2", out_onehot, 32'h2);
        end
        step(32'h0, 1, 1, "bp.rel");
        chk("bp.oh4", out_onehot, 32'h4);
        step(32'h0, 1, 1, "bp.done");

        step(32'h8, 0, 0, "drop.set");
        for (int i = 0; i < 3; i++) step(32'h8, 0, 0, "drop.merge");
        chk("drop.cnt3", 32'(drop_cnt), 32'd3);
        step(32'h0, 1, 1, "drop.offer");
        chk("drop.oh3", out_onehot, 32'h8);
        step(32'h0, 1, 1, "drop.grant");
        chk("drop.once", 32'(out_valid), 32'd0);
        step(32'h8, 0, 0, "sat.set");
        for (int i = 0; i < 300; i++) step(32'h8, 0, 0, "sat.merge");
        chk("sat.255", 32'(drop_cnt), 32'd255);
        step(32'h0, 1, 1, "sat.offer");
        step(32'h0, 1, 1, "sat.grant");

        async_reset("rst1");
        step(32'h80, 1, 1, "rereq.offer");
        step(32'h80, 1, 1, "rereq.hs");
        chk("rereq.pend7", 32'(pending[7]), 32'd1);
        chk("rereq.oh7", out_onehot, 32'h80);
        chk("rereq.drop", 32'(drop_cnt), 32'd0);
        step(32'h0, 1, 1, "rereq.grant2");
        step(32'h0, 1, 1, "rereq.idle");

        step(32'h30, 1, 0, "en.offer");
        step(32'h0, 0, 0, "en.hold");
        chk("en.held", 32'(out_valid), 32'd1);
        step(32'h0, 0, 1, "en.done");
        chk("en.noneq", 32'(out_valid), 32'd0);
        step(32'h0, 0, 0, "en.idle");

        step(32'h0, 1, 0, "mid.offer");
        chk("mid.valid", 32'(out_valid), 32'd1);
        async_reset("mid");

        for (int n = 0; n < 2000; n++) begin
            r = ($urandom_range(0, 1) == 0) ? '0 : ($urandom & $urandom & $urandom);
            step(r, $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 7, "rand");
            if ($urandom_range(0, 299) == 0) async_reset("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
